// File: rtl/mock_uart_pkg.sv
// mock_uart_pkg: register map and status layout shared by the mock UART blocks
package mock_uart_pkg;
  localparam logic [7:0] OffThr  = 8'h00;
  localparam logic [7:0] OffLsr  = 8'h04;
  localparam logic [7:0] OffDrop = 8'h08;
  localparam logic [7:0] OffIer  = 8'h0C;
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  level;
    logic [5:0]  rsvd_lo;
    logic        full;
    logic        empty;
  } lsr_t;
endpackage

// File: rtl/mock_uart_tx_fifo.sv
// mock_uart_tx_fifo: single-channel character FIFO with fill level
module mock_uart_tx_fifo #(
  parameter int Depth = 16,
  localparam int PtrW = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          empty,
  output logic          full,
  output logic [PtrW:0] level
);
  logic [7:0] mem [Depth];
  logic [PtrW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign empty = level == '0;
  assign full = level == (PtrW+1)'(Depth);
  assign rdata = mem[rptr];
  // pointers and level; a simultaneous push and pop leaves the level unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      level <= level + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end
  end
  // storage needs no reset: contents behind an empty level are never observed
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/mock_uart_apb_mc.sv
// mock_uart_apb_mc: multi-channel APB mock UART draining onto one character stream
module mock_uart_apb_mc
  import mock_uart_pkg::*;
#(
  parameter int NumChannels = 4,
  parameter int FifoDepth = 16,
  parameter int AddrWidth = 32,
  parameter int ChanLsb = 8,
  parameter bit DropOnFull = 1'b0,
  localparam int ChanW = NumChannels > 1 ? $clog2(NumChannels) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [AddrWidth-1:0]   paddr_i,
  input  logic [31:0]            pwdata_i,
  output logic [31:0]            prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [ChanW-1:0]       tx_chan_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_eol_o,
  output logic [NumChannels-1:0] irq_o
);
  localparam int LvlW = $clog2(FifoDepth) + 1;
  logic [3:0] chan_raw;
  logic [ChanW-1:0] chan, ptr, pick, grant, lock_chan, idx;
  logic [ChanLsb-1:0] off;
  logic access, is_thr, is_lsr, is_drop, is_ier, err, reg_wr, thr_wr, stall, locked;
  logic [NumChannels-1:0] push, pop, empty, full, ier, irq_q;
  logic [NumChannels-1:0][15:0] drop_cnt;
  logic [7:0] fifo_rdata [NumChannels];
  logic [LvlW-1:0] fifo_level [NumChannels];
  lsr_t lsr;
  logic unused_bits;
  // four index bits are decoded so that indices beyond NumChannels can be rejected
  assign chan_raw = paddr_i[ChanLsb +: 4];
  assign chan = chan_raw[ChanW-1:0];
  assign off = paddr_i[ChanLsb-1:0];
  assign unused_bits = ^{paddr_i[AddrWidth-1:ChanLsb+4], pwdata_i[31:8]};
  assign access = psel_i & penable_i;
  assign is_thr = off == ChanLsb'(OffThr);
  assign is_lsr = off == ChanLsb'(OffLsr);
  assign is_drop = off == ChanLsb'(OffDrop);
  assign is_ier = off == ChanLsb'(OffIer);
  assign err = (int'(chan_raw) >= NumChannels) | ~(is_thr | is_lsr | is_drop | is_ier);
  assign reg_wr = access & pwrite_i & ~err;
  assign thr_wr = reg_wr & is_thr;
  assign stall = thr_wr & full[chan] & ~DropOnFull;
  assign pready_o = access & ~stall;
  assign pslverr_o = access & err;
  assign lsr = '{rsvd_hi: '0, level: 8'(fifo_level[chan]), rsvd_lo: '0, full: full[chan], empty: empty[chan]};
  assign prdata_o = (access & ~pwrite_i & ~err) ?
                    (is_lsr ? 32'(lsr) : is_drop ? 32'(drop_cnt[chan]) : is_ier ? 32'(ier[chan]) : '0) : '0;
  for (genvar i = 0; i < NumChannels; i++) begin : g_chan
    assign push[i] = thr_wr & (chan == ChanW'(i)) & ~full[i];
    assign pop[i] = tx_valid_o & tx_ready_i & (grant == ChanW'(i));
    mock_uart_tx_fifo #(.Depth(FifoDepth)) u_fifo (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .push  (push[i]),
      .wdata (pwdata_i[7:0]),
      .pop   (pop[i]),
      .rdata (fifo_rdata[i]),
      .empty (empty[i]),
      .full  (full[i]),
      .level (fifo_level[i])
    );
  end
  // per-channel interrupt enables, saturating drop counters and registered irq
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ier <= '0;
      drop_cnt <= '0;
      irq_q <= '0;
    end else begin
      irq_q <= ier & empty;
      for (int c = 0; c < NumChannels; c++) begin
        if (reg_wr & (chan == ChanW'(c)) & is_ier) ier[c] <= pwdata_i[0];
        if (reg_wr & (chan == ChanW'(c)) & is_drop) drop_cnt[c] <= '0;
        else if (thr_wr & DropOnFull & (chan == ChanW'(c)) & full[c] & (drop_cnt[c] != 16'hFFFF))
          drop_cnt[c] <= drop_cnt[c] + 1'b1;
      end
    end
  end
  assign irq_o = irq_q;
  // round-robin search for the first non-empty channel at or after ptr
  always_comb begin
    pick = ptr;
    idx = '0;
    for (int k = NumChannels - 1; k >= 0; k--) begin
      idx = ChanW'((int'(ptr) + k) % NumChannels);
      if (!empty[idx]) pick = idx;
    end
  end
  assign grant = locked ? lock_chan : pick;
  assign tx_valid_o = |(~empty);
  assign tx_chan_o = grant;
  assign tx_data_o = fifo_rdata[grant];
  assign tx_eol_o = tx_data_o == 8'h0A;
  // hold the grant across back-pressure and move past the served channel on each handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
      locked <= 1'b0;
      lock_chan <= '0;
    end else begin
      locked <= tx_valid_o & ~tx_ready_i;
      lock_chan <= grant;
      if (tx_valid_o & tx_ready_i) ptr <= (grant == ChanW'(NumChannels - 1)) ? '0 : grant + 1'b1;
    end
  end
endmodule

// File: tb/tb_mock_uart_apb_mc.sv
// tb_mock_uart_apb_mc: randomized self-checking bench with a queue-based channel model
module tb_mock_uart_apb_mc;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic psel = 0, penable = 0, pwrite = 0, which = 0, tx_ready = 0, tx_ready1 = 0;
  logic [31:0] paddr = 0, pwdata = 0;
  logic [31:0] prdata0, prdata1, prdata;
  logic pready0, pready1, pslverr0, pslverr1, pready, pslverr;
  logic tx_valid, tx_valid1, tx_eol, tx_eol1;
  logic [1:0] tx_chan, tx_chan1;
  logic [7:0] tx_data, tx_data1;
  logic [3:0] irq, irq1;
  assign pready = which ? pready1 : pready0;
  assign pslverr = which ? pslverr1 : pslverr0;
  assign prdata = which ? prdata1 : prdata0;

  mock_uart_apb_mc #(.NumChannels(4), .FifoDepth(4), .AddrWidth(32), .ChanLsb(8), .DropOnFull(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel & ~which), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_chan_o(tx_chan), .tx_data_o(tx_data),
    .tx_eol_o(tx_eol), .irq_o(irq));

  mock_uart_apb_mc #(.NumChannels(4), .FifoDepth(4), .AddrWidth(32), .ChanLsb(8), .DropOnFull(1'b1)) dut_drop (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel & which), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata1), .pready_o(pready1), .pslverr_o(pslverr1),
    .tx_valid_o(tx_valid1), .tx_ready_i(tx_ready1), .tx_chan_o(tx_chan1), .tx_data_o(tx_data1),
    .tx_eol_o(tx_eol1), .irq_o(irq1));

  int errors = 0, checks = 0;
  logic [7:0] q [4][$];
  logic [9:0] obs [$];
  int last = 3, lock_ch = 0, eol_seen = 0;
  bit locked_m = 0;

  function automatic bit busy();
    for (int c = 0; c < 4; c++) if (q[c].size() != 0) return 1;
    return 0;
  endfunction

  // stream monitor: round-robin over the model queues, holding the choice under back-pressure
  always @(negedge clk) if (rst_n) begin : mon
    int e;
    bit any;
    any = busy();
    checks++;
    if (tx_valid !== any) begin
      errors++;
      $display("FAIL stream_valid: got %b required %b", tx_valid, any);
    end
    if (tx_valid && any) begin
      e = -1;
      if (locked_m) e = lock_ch;
      else for (int i = 1; i <= 4; i++) if (e < 0 && q[(last + i) % 4].size() != 0) e = (last + i) % 4;
      checks++;
      if (tx_chan !== 2'(e) || tx_data !== q[e][0] || tx_eol !== (q[e][0] == 8'h0A)) begin
        errors++;
        $display("FAIL stream_char: chan/data/eol got %0d/%h/%b required %0d/%h/%b",
                 tx_chan, tx_data, tx_eol, e, q[e][0], q[e][0] == 8'h0A);
      end
      if (tx_ready) begin
        obs.push_back({2'(e), q[e][0]});
        if (tx_eol) eol_seen++;
        void'(q[e].pop_front());
        last = e;
        locked_m = 0;
      end else begin
        locked_m = 1;
        lock_ch = e;
      end
    end
  end

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int waits);
    waits = 0;
    @(posedge clk); #1 psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1 penable = 1;
    @(negedge clk);
    while (!pready && waits < 200) begin waits++; @(negedge clk); end
    if (!pready) begin
      checks++; errors++;
      $display("FAIL apb_timeout addr=%h: pready got 0 required 1", addr);
    end
    rd = prdata;
    er = pslverr;
    @(posedge clk);
    if (!which && wr && addr[7:0] == 8'h00 && addr[11:8] < 4) q[addr[9:8]].push_back(wd[7:0]);
    #1 psel = 0; penable = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (busy() && n < 300) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (n >= 300 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: valid got %b required 0 (cycles %0d)", tx_valid, n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int w;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx_valid, pready0, pslverr0, irq} !== 7'b0 || prdata0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid/ready/err/irq/prdata got %b/%b/%b/%h/%h required 0",
               tx_valid, pready0, pslverr0, irq, prdata0);
    end
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      apb(0, {20'h0, 4'(c), 8'h04}, 0, rd, er, w);
      checks++;
      if (rd !== 32'h0001 || er !== 1'b0) begin
        errors++;
        $display("FAIL reset_lsr ch%0d: got %h/%b required 00000001/0", c, rd, er);
      end
    end
  endtask

  task automatic test_hello();
    logic [31:0] rd; logic er; int w;
    logic [7:0] msg [3];
    msg = '{8'h48, 8'h69, 8'h0A};
    obs.delete(); eol_seen = 0; tx_ready = 1;
    foreach (msg[i]) apb(1, 32'h000, {24'h0, msg[i]}, rd, er, w);
    wait_drain();
    checks++;
    if (obs.size() != 3 || eol_seen != 1) begin
      errors++;
      $display("FAIL hello_count: chars/eol got %0d/%0d required 3/1", obs.size(), eol_seen);
    end else foreach (msg[i]) begin
      checks++;
      if (obs[i] !== {2'd0, msg[i]}) begin
        errors++;
        $display("FAIL hello_char%0d: got %h required %h", i, obs[i], {2'd0, msg[i]});
      end
    end
    apb(0, 32'h004, 0, rd, er, w);
    checks++;
    if (rd !== 32'h0001) begin
      errors++;
      $display("FAIL hello_lsr: got %h required 00000001", rd);
    end
  endtask

  task automatic test_interleave();
    logic [31:0] rd; logic er; int w;
    logic [9:0] exp [4];
    exp = '{{2'd1, 8'h41}, {2'd2, 8'h78}, {2'd1, 8'h42}, {2'd2, 8'h79}};
    obs.delete(); tx_ready = 0;
    apb(1, 32'h100, 32'h41, rd, er, w);
    apb(1, 32'h100, 32'h42, rd, er, w);
    apb(1, 32'h200, 32'h78, rd, er, w);
    apb(1, 32'h200, 32'h79, rd, er, w);
    tx_ready = 1;
    wait_drain();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs.size() != 4 || obs[i] !== exp[i]) begin
        errors++;
        $display("FAIL interleave%0d: got %h required %h", i, obs.size() > i ? obs[i] : 10'h3FF, exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] rd; logic er; int w, w5;
    tx_ready = 0;
    for (int i = 0; i < 4; i++) begin
      apb(1, 32'h000, $urandom_range(0, 255), rd, er, w);
      checks++;
      if (w != 0) begin errors++; $display("FAIL stall_fill%0d: waits got %0d required 0", i, w); end
    end
    apb(0, 32'h004, 0, rd, er, w);
    checks++;
    if (rd !== 32'h0402) begin errors++; $display("FAIL stall_lsr_full: got %h required 00000402", rd); end
    fork
      apb(1, 32'h000, 32'h5A, rd, er, w5);
      begin
        repeat (4) @(posedge clk);
        #1 tx_ready = 1;
        @(negedge clk);
        checks++;
        if (pready0 !== 1'b0) begin errors++; $display("FAIL stall_same_cycle: pready got %b required 0", pready0); end
        @(posedge clk); #1 tx_ready = 0;
        @(negedge clk);
        checks++;
        if (pready0 !== 1'b1) begin errors++; $display("FAIL stall_release: pready got %b required 1", pready0); end
      end
    join
    checks++;
    if (w5 != 3) begin errors++; $display("FAIL stall_waits: got %0d required 3", w5); end
    apb(0, 32'h004, 0, rd, er, w);
    checks++;
    if (rd !== 32'h0402) begin errors++; $display("FAIL stall_lsr_after: got %h required 00000402", rd); end
    tx_ready = 1;
    wait_drain();
  endtask

  task automatic test_drop();
    logic [31:0] rd; logic er; int w;
    which = 1;
    for (int i = 0; i < 10; i++) begin
      apb(1, 32'h300, $urandom_range(0, 255), rd, er, w);
      checks++;
      if (w != 0 || er !== 1'b0) begin errors++; $display("FAIL drop_write%0d: waits/err got %0d/%b required 0/0", i, w, er); end
    end
    apb(0, 32'h304, 0, rd, er, w);
    checks++;
    if (rd !== 32'h0402) begin errors++; $display("FAIL drop_lsr: got %h required 00000402", rd); end
    apb(0, 32'h308, 0, rd, er, w);
    checks++;
    if (rd !== 32'd6) begin errors++; $display("FAIL drop_count: got %0d required 6", rd); end
    apb(1, 32'h308, $urandom, rd, er, w);
    apb(0, 32'h308, 0, rd, er, w);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL drop_clear: got %0d required 0", rd); end
    which = 0;
  endtask

  task automatic test_error();
    logic [31:0] rd; logic er; int w;
    logic [32:0] cases [4];
    tx_ready = 1;
    cases = '{{1'b0, 32'h500}, {1'b1, 32'h500}, {1'b1, 32'h010}, {1'b0, 32'h010}};
    foreach (cases[i]) begin
      apb(cases[i][32], cases[i][31:0], 32'h51, rd, er, w);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
        errors++;
        $display("FAIL error_resp%0d: err/prdata got %b/%h required 1/00000000", i, er, rd);
      end
    end
    for (int c = 0; c < 2; c++) begin
      apb(0, {20'h0, 4'(c), 8'h04}, 0, rd, er, w);
      checks++;
      if (er !== 1'b0 || rd !== 32'h0001) begin
        errors++;
        $display("FAIL error_nochange ch%0d: err/lsr got %b/%h required 0/00000001", c, er, rd);
      end
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic er; int w;
    tx_ready = 1;
    apb(1, 32'h00C, 32'h1, rd, er, w);
    @(posedge clk); #1;
    checks++;
    if (irq !== 4'b0001) begin errors++; $display("FAIL irq_enable: got %b required 0001", irq); end
    apb(0, 32'h00C, 0, rd, er, w);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL irq_ier_read: got %h required 00000001", rd); end
    tx_ready = 0;
    apb(1, 32'h000, 32'h5A, rd, er, w);
    @(posedge clk); #1;
    checks++;
    if (irq[0] !== 1'b0) begin errors++; $display("FAIL irq_busy: got %b required 0", irq[0]); end
    tx_ready = 1;
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 4'b0001) begin errors++; $display("FAIL irq_drained: got %b required 0001", irq); end
    apb(1, 32'h00C, 32'h0, rd, er, w);
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int w;
    bit done = 0;
    fork
      while (!done) begin @(posedge clk); #1 tx_ready = 1'($urandom_range(0, 1)); end
      begin
        for (int i = 0; i < 40; i++) apb(1, {22'h0, 2'($urandom_range(0, 3)), 8'h00}, $urandom, rd, er, w);
        done = 1;
      end
    join
    #1 tx_ready = 1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int w;
    tx_ready = 0;
    apb(1, 32'h000, 32'h31, rd, er, w);
    apb(1, 32'h200, 32'h32, rd, er, w);
    apb(1, 32'h000, 32'h33, rd, er, w);
    tx_ready = 1;
    @(posedge clk); #1 rst_n = 0;
    for (int c = 0; c < 4; c++) q[c].delete();
    last = 3; locked_m = 0;
    #1;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid: got %b required 0", tx_valid); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      apb(0, {20'h0, 4'(c), 8'h04}, 0, rd, er, w);
      checks++;
      if (rd !== 32'h0001) begin errors++; $display("FAIL reset_mid_lsr ch%0d: got %h required 00000001", c, rd); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hello();
    test_interleave();
    test_stall();
    test_drop();
    test_error();
    test_irq();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mock_uart_apb_mc.md
Name: mock_uart_apb_mc

Overview:
Multi-channel, parametrised successor to the single-channel testbench mock UART. It is an APB slave exposing NumChannels independent transmit channels, each with its own register window and character FIFO. A round-robin arbiter drains all channels onto one valid/ready character stream, which the testbench printer consumes. It sits behind the same AXI -> AXI-Lite -> APB bridge chain (32-bit APB data) in the cluster testbench.

Parameters:
NumChannels, 4, number of channels (1..16).
FifoDepth, 16, TX FIFO entries per channel (power of two, >=2).
AddrWidth, 32, APB address width.
ChanLsb, 8, lowest address bit of the channel index; each channel window is 2^ChanLsb bytes.
DropOnFull, 0, 1 = a write to a full FIFO completes immediately and is dropped; 0 = pready is held low until space frees.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB write
paddr_i  in  AddrWidth  APB address
pwdata_i  in  32  APB write data
prdata_o  out  32  APB read data
pready_o  out  1  APB ready
pslverr_o  out  1  APB error
tx_valid_o  out  1  output character valid
tx_ready_i  in  1  output consumer ready
tx_chan_o  out  $clog2(NumChannels) (min 1)  source channel
tx_data_o  out  8  character
tx_eol_o  out  1  tx_data_o == 8'h0A
irq_o  out  NumChannels  per-channel TX-empty interrupt

Behaviour:
- Reset (async, rst_ni low): FIFOs empty; drop counters 0; IER 0; arbiter pointer at channel 0; outputs tx_valid_o=0, pready_o=0, pslverr_o=0, prdata_o=0, irq_o=0.
- Decode: chan = paddr_i[ChanLsb +: ChanW]; off = paddr_i[ChanLsb-1:0]. Register offsets:
  - 0x0 THR: write stores pwdata_i[7:0]; read returns 0.
  - 0x4 LSR (RO): bit0 TX_EMPTY, bit1 TX_FULL, bits[15:8] fill level.
  - 0x8 DROP: saturating 16-bit count of dropped characters; any write clears it.
  - 0xC IER: bit0 enables irq_o[chan].
- APB access phase (psel_i & penable_i): reads, and writes other than THR, complete in the first access cycle (pready_o=1, combinational).
- Error response: chan >= NumChannels, or an unmapped offset, gives pready_o=1, pslverr_o=1, no state change, prdata_o=0.
- THR write to a non-full FIFO: push, pready_o=1.
- THR write to a full FIFO:
  - DropOnFull=0: pready_o=0 until count < FifoDepth; push in the completing cycle.
  - DropOnFull=1: pready_o=1, no push, DROP increments (saturating at 16'hFFFF).
- Full is evaluated on the current registered count. A pop in the same cycle does not admit the write; the write completes the next cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged and ordering is preserved.
- Output arbiter:
  - Round-robin over non-empty FIFOs, starting after the last granted channel.
  - Grant is locked while tx_valid_o & !tx_ready_i; chan and data stay stable.
  - Pop happens on tx_valid_o & tx_ready_i. The pointer advances to the next channel after each handshake, so successive characters interleave between channels.
  - tx_valid_o is asserted in the cycle after data is pushed into an empty FIFO (one-cycle write-to-output latency).
- irq_o[c] = IER[c] & TX_EMPTY[c], registered.
- A reset mid-transfer discards all FIFO contents and any pending APB stall.

Decomposition:
- Package mock_uart_pkg holds the register offset localparams, LSR bit positions, and the lsr_t packed struct.
- Sub-module mock_uart_tx_fifo: single-channel FIFO (push/pop/full/empty/level, FifoDepth parameter), instantiated NumChannels times.
- The arbiter and APB decode stay in the top module.

Test Plan:
- Write 'H','i',0x0A to ch0 THR (0x000) with tx_ready_i=1 -> stream H,i,0x0A on chan 0; tx_eol_o=1 on the third character only; LSR read at 0x004 returns 0x0001.
- Preload ch1 with 'A','B' and ch2 with 'x','y' while tx_ready_i=0, then release -> output order A,x,B,y with chan 1,2,1,2.
- DropOnFull=0, FifoDepth=4: 5 writes to ch0 with tx_ready_i=0 -> 5th write stalls (pready_o=0); one pop makes it complete the next cycle; LSR shows level 4, TX_FULL=1.
- DropOnFull=1: 6 writes to a full ch3 -> all pready_o=1; DROP (0x308) reads 6; writing 0x308 then reading returns 0.
- Access to chan 5 with NumChannels=4, or offset 0x10 -> pslverr_o=1, prdata_o=0, no FIFO change.
- Set IER ch0=1 with ch0 empty -> irq_o[0]=1; push one char -> irq_o[0]=0; drain -> 1. Assert rst_ni mid-stream -> tx_valid_o=0 immediately and all FIFOs empty.
